// File: rtl/memory_arbiter_if.sv
// Bus bundle for memory_arbiter: two requester ports plus the shared single-ported RAM lines.
// slave = arbiter view; master = surrounding system (requesters and RAM model).
interface memory_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req0, req1;
  logic                  lock0, lock1;
  logic                  we0, we1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  ack0, ack1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  logic [1:0]            grant;
  logic [ADDR_WIDTH-1:0] memAddress;
  logic                  memReadEnable, memWriteEnable;
  logic [DATA_WIDTH-1:0] memWriteData;
  logic [DATA_WIDTH-1:0] memReadData;

  modport slave (
    input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, memReadData,
    output ack0, ack1, rdata0, rdata1, grant,
           memAddress, memReadEnable, memWriteEnable, memWriteData
  );

  modport master (
    output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, memReadData,
    input  ack0, ack1, rdata0, rdata1, grant,
           memAddress, memReadEnable, memWriteEnable, memWriteData
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port arbiter for a shared single-ported RAM with bounded locked bursts.
// Optional MEMORY_ARBITER_ROUND_ROBIN_EN: round-robin ties (default: fixed priority, port 0 wins).
module memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 16
) (
  input  logic            clk,
  input  logic            rst,
  memory_arbiter_if.slave bus
);
  localparam int            CW        = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_MAX  = CW'(MAX_LOCK);
  localparam logic [CW-1:0] LOCK_LAST = CW'(MAX_LOCK - 1);

  typedef enum logic [2:0] {IDLE, ACCESS0, ACCESS1, DONE0, DONE1} state_t;

  state_t                state, next_state;
  logic [CW-1:0]         lock_count;
  logic                  lock_room;
  logic                  room0, room1;
  logic                  tie0;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] wdata_sel;
  logic                  ren, wen;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  // lock_count counts re-grants, so a burst of MAX_LOCK accesses needs MAX_LOCK-1 of them.
  assign lock_room = (lock_count < LOCK_LAST);

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  logic last_grant;
  assign tie0  = last_grant;
  assign room0 = lock_room;
`else
  assign tie0  = 1'b1;
  assign room0 = 1'b1;
`endif
  assign room1 = lock_room;

  function automatic state_t pick(input logic r0, input logic r1, input logic t0);
    if (r0 && r1) return t0 ? ACCESS0 : ACCESS1;
    if (r0)       return ACCESS0;
    if (r1)       return ACCESS1;
    return IDLE;
  endfunction

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    next_state = pick(bus.req0, bus.req1, tie0);
      ACCESS0: next_state = DONE0;
      ACCESS1: next_state = DONE1;
      DONE0: begin
        if (bus.lock0 && bus.req0 && (room0 || !bus.req1)) next_state = ACCESS0;
        else next_state = pick(bus.req0 && bus.lock0, bus.req1, tie0);
      end
      DONE1: begin
        if (bus.lock1 && bus.req1 && (room1 || !bus.req0)) next_state = ACCESS1;
        else next_state = pick(bus.req0, bus.req1 && bus.lock1, tie0);
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lock_count <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state <= next_state;
      if ((state == DONE0 && next_state == ACCESS0) ||
          (state == DONE1 && next_state == ACCESS1)) begin
        if (lock_count != LOCK_MAX) lock_count <= lock_count + CW'(1);
      end else if (next_state == IDLE || next_state == ACCESS0 || next_state == ACCESS1) begin
        lock_count <= '0;
      end
      if (state == ACCESS0 && !bus.we0) rdata0_q <= bus.memReadData;
      if (state == ACCESS1 && !bus.we1) rdata1_q <= bus.memReadData;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      if (next_state == ACCESS0)      last_grant <= 1'b0;
      else if (next_state == ACCESS1) last_grant <= 1'b1;
`endif
    end
  end

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    ren       = 1'b0;
    wen       = 1'b0;
    unique case (state)
      ACCESS0: begin
        addr_sel  = bus.addr0;
        wdata_sel = bus.wdata0;
        ren       = ~bus.we0;
        wen       = bus.we0;
      end
      ACCESS1: begin
        addr_sel  = bus.addr1;
        wdata_sel = bus.wdata1;
        ren       = ~bus.we1;
        wen       = bus.we1;
      end
      default: ;
    endcase
  end

  assign bus.memAddress     = addr_sel;
  assign bus.memWriteData   = wdata_sel;
  assign bus.memReadEnable  = ren;
  // Reset kills the write strobe in the same cycle so an aborted write never lands.
  assign bus.memWriteEnable = wen & ~rst;

  assign bus.grant  = (state == ACCESS0 || state == DONE0) ? 2'b01 :
                      (state == ACCESS1 || state == DONE1) ? 2'b10 : 2'b00;
  assign bus.ack0   = (state == DONE0);
  assign bus.ack1   = (state == DONE1);
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;
endmodule
